// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 memory controller slice.
package chip8_pkg;

  typedef enum logic [1:0] {MC_FONT, MC_LOAD, MC_RUN} mc_state_t;

  localparam int unsigned FONT_BYTES = 80;
  localparam logic [11:0] ROM_BASE = 12'h200;

  // Sixteen 5-byte glyphs, digits 0..F in order.
  localparam logic [7:0] FONT_ROM [0:FONT_BYTES-1] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

endpackage

// File: rtl/chip8_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 = CPU, bit 1 = sprite fetcher.
module chip8_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Starts as if requester 1 was served last, so the first tie goes to requester 0.
  logic last_gnt1;

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req == 2'b11) gnt = last_gnt1 ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_gnt1 <= 1'b1;
    else if (|gnt) last_gnt1 <= gnt[1];
  end

endmodule

// File: rtl/chip8_mem_ctrl.sv
// CHIP-8 RAM sequencer: font copy after reset, ROM load, then CPU/sprite arbitration.
module chip8_mem_ctrl #(
  parameter int unsigned        ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] FONT_BASE = '0,
  parameter logic [ADDR_W-1:0] ROM_BASE  = ADDR_W'(chip8_pkg::ROM_BASE)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  input  logic              ld_done,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_rvalid,
  output logic [7:0]        cpu_rdata,
  input  logic              gfx_valid,
  output logic              gfx_ready,
  input  logic [ADDR_W-1:0] gfx_addr,
  output logic              gfx_rvalid,
  output logic [7:0]        gfx_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              booted,
  output logic              ld_err
);

  import chip8_pkg::*;

  localparam logic [6:0] FONT_LAST = 7'(FONT_BYTES - 1);

  mc_state_t  state_q, state_d;
  logic [6:0] font_idx;
  logic       font_arm;
  logic [1:0] gnt;
  logic       rd_pend, rd_gfx;
  logic [7:0] cpu_rdata_q, gfx_rdata_q;

  chip8_rr_arb2 u_arb (
    .clk (clk_in),
    .rst (rst_in),
    .en  (state_q == MC_RUN),
    .req ({gfx_valid, cpu_valid}),
    .gnt (gnt)
  );

  // font_arm holds off the first font write until the cycle after reset release,
  // keeping every output low while reset is asserted without a combinational reset path.
  always_comb begin
    state_d   = state_q;
    ld_ready  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      MC_FONT: begin
        if (font_arm) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = FONT_BASE + ADDR_W'(font_idx);
          mem_wdata = FONT_ROM[font_idx];
          if (font_idx == FONT_LAST) state_d = MC_LOAD;
        end
      end
      MC_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          if (ld_addr >= ROM_BASE) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_data;
          end
        end else if (ld_done) begin
          state_d = MC_RUN;
        end
      end
      MC_RUN: begin
        if (gnt[0]) begin
          mem_en    = 1'b1;
          mem_we    = cpu_we;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
        end else if (gnt[1]) begin
          mem_en   = 1'b1;
          mem_addr = gfx_addr;
        end
      end
      default: state_d = MC_FONT;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= MC_FONT;
      font_idx    <= '0;
      font_arm    <= 1'b0;
      ld_err      <= 1'b0;
      rd_pend     <= 1'b0;
      rd_gfx      <= 1'b0;
      cpu_rdata_q <= '0;
      gfx_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      font_arm <= 1'b1;
      if (state_q == MC_FONT && font_arm) font_idx <= font_idx + 7'd1;
      if (state_q == MC_LOAD && ld_valid && ld_addr < ROM_BASE) ld_err <= 1'b1;
      rd_pend <= (gnt[0] & ~cpu_we) | gnt[1];
      rd_gfx  <= gnt[1];
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (gfx_rvalid) gfx_rdata_q <= mem_rdata;
    end
  end

  // Read data arrives from the RAM the cycle after the grant; the tag steers it.
  assign cpu_rvalid = rd_pend & ~rd_gfx;
  assign gfx_rvalid = rd_pend & rd_gfx;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign gfx_rdata  = gfx_rvalid ? mem_rdata : gfx_rdata_q;
  assign cpu_ready  = gnt[0];
  assign gfx_ready  = gnt[1];
  assign booted     = (state_q == MC_RUN);

endmodule

// File: tb/tb_chip8_mem_ctrl.sv
// Self-checking bench for chip8_mem_ctrl with a behavioural RAM and reference memory image.
module tb_chip8_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_valid = 1'b0, ld_done = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        cpu_valid = 1'b0, cpu_we = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        gfx_valid = 1'b0;
  logic [11:0] gfx_addr = '0;
  logic        ld_ready, cpu_ready, cpu_rvalid, gfx_ready, gfx_rvalid;
  logic [7:0]  cpu_rdata, gfx_rdata;
  logic        mem_en, mem_we, booted, ld_err;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;

  logic [7:0]   ram     [4096];
  logic [7:0]   ref_mem [4096];
  logic [7:0]   font_exp [80];
  logic [639:0] font_bits;
  logic         last_was_gfx;
  int           checks = 0;
  int           errors = 0;

  chip8_mem_ctrl #(.ADDR_W(12), .FONT_BASE(12'h000), .ROM_BASE(12'h200)) dut (
    .clk_in(clk), .rst_in(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .gfx_valid(gfx_valid), .gfx_ready(gfx_ready), .gfx_addr(gfx_addr),
    .gfx_rvalid(gfx_rvalid), .gfx_rdata(gfx_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .booted(booted), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, read data one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  function automatic logic [11:0] pick_addr();
    case ($urandom % 3)
      0:       return 12'h300 + 12'($urandom % 16);
      1:       return 12'($urandom % 80);
      default: return 12'h200 + 12'($urandom % 5);
    endcase
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    ld_valid = 0; ld_done = 0; cpu_valid = 0; cpu_we = 0; gfx_valid = 0;
    #1;
    checks++;
    if ({mem_en, mem_we, ld_ready, cpu_ready, gfx_ready, cpu_rvalid, gfx_rvalid, booted, ld_err} !== 9'b0 ||
        mem_addr !== 12'h0 || mem_wdata !== 8'h0 || cpu_rdata !== 8'h0 || gfx_rdata !== 8'h0)
      begin errors++; $display("FAIL reset_outputs: en=%b we=%b ldr=%b cr=%b gr=%b crv=%b grv=%b boot=%b err=%b addr=%h, want all 0",
        mem_en, mem_we, ld_ready, cpu_ready, gfx_ready, cpu_rvalid, gfx_rvalid, booted, ld_err, mem_addr); end
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (cpu_rvalid !== 1'b0 || gfx_rvalid !== 1'b0 || mem_en !== 1'b0)
        begin errors++; $display("FAIL reset_hold: crv=%b grv=%b en=%b, want 0 0 0", cpu_rvalid, gfx_rvalid, mem_en); end
    end
    @(negedge clk);
    rst = 1'b0;
    last_was_gfx = 1'b1;
  endtask

  task automatic test_font(input int stop_at);
    int i = 0;
    int cyc = 0;
    while (i < stop_at && cyc < 300) begin
      @(posedge clk); #2;
      cyc++;
      checks++;
      if (ld_ready !== 1'b0 || cpu_ready !== 1'b0 || gfx_ready !== 1'b0)
        begin errors++; $display("FAIL font_readys: ld=%b cpu=%b gfx=%b, want 0 0 0", ld_ready, cpu_ready, gfx_ready); end
      if (mem_en) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 12'(i) || mem_wdata !== font_exp[i])
          begin errors++; $display("FAIL font_write %0d: we=%b addr=%h data=%h, want we=1 addr=%h data=%h",
            i, mem_we, mem_addr, mem_wdata, 12'(i), font_exp[i]); end
        ref_mem[i] = font_exp[i];
        i++;
      end
    end
    checks++;
    if (i != stop_at) begin errors++; $display("FAIL font_timeout: got %0d writes, want %0d", i, stop_at); end
    if (stop_at == 80) begin
      @(posedge clk); #2;
      checks++;
      if (ld_ready !== 1'b1 || mem_en !== 1'b0 || booted !== 1'b0)
        begin errors++; $display("FAIL font_to_load: ld_ready=%b en=%b booted=%b, want 1 0 0", ld_ready, mem_en, booted); end
      checks++;
      if (ram[0] !== 8'hF0 || ram[79] !== 8'h80)
        begin errors++; $display("FAIL font_ends: ram[0]=%h ram[4F]=%h, want F0 80", ram[0], ram[79]); end
    end
  endtask

  task automatic test_load;
    logic [7:0]  rom [4];
    logic [11:0] a;
    logic [7:0]  d;
    rom = '{8'hA2, 8'h2A, 8'h60, 8'h0C};
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k < 4) begin a = 12'h200 + 12'(k); d = rom[k]; end
      else begin a = 12'h205 + 12'($urandom % 256); d = 8'($urandom); end
      ld_valid = 1; ld_addr = a; ld_data = d;
      #1;
      checks++;
      if (ld_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== a || mem_wdata !== d)
        begin errors++; $display("FAIL load_write %0d: rdy=%b en=%b we=%b addr=%h data=%h, want 1 1 1 %h %h",
          k, ld_ready, mem_en, mem_we, mem_addr, mem_wdata, a, d); end
      ref_mem[a] = d;
    end
    @(posedge clk); #1;
    ld_addr = 12'h100; ld_data = 8'hEE;
    #1;
    checks++;
    if (ld_ready !== 1'b1 || mem_en !== 1'b0)
      begin errors++; $display("FAIL load_low_drop: rdy=%b en=%b, want 1 0", ld_ready, mem_en); end
    @(posedge clk); #1;
    checks++;
    if (ld_err !== 1'b1) begin errors++; $display("FAIL load_err_set: ld_err=%b, want 1", ld_err); end
    ld_addr = 12'h204; ld_data = 8'h77; ld_done = 1;
    #1;
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h204 || mem_wdata !== 8'h77)
      begin errors++; $display("FAIL load_valid_done: en=%b addr=%h data=%h, want 1 204 77", mem_en, mem_addr, mem_wdata); end
    ref_mem[12'h204] = 8'h77;
    @(posedge clk); #1;
    ld_valid = 0;
    #1;
    checks++;
    if (booted !== 1'b0 || ld_ready !== 1'b1 || mem_en !== 1'b0)
      begin errors++; $display("FAIL load_stay: booted=%b rdy=%b en=%b, want 0 1 0", booted, ld_ready, mem_en); end
    @(posedge clk); #1;
    ld_done = 0;
    checks++;
    if (booted !== 1'b1 || ld_ready !== 1'b0 || ld_err !== 1'b1)
      begin errors++; $display("FAIL load_booted: booted=%b rdy=%b err=%b, want 1 0 1", booted, ld_ready, ld_err); end
    checks++;
    if (ram[12'h200] !== 8'hA2 || ram[12'h201] !== 8'h2A || ram[12'h202] !== 8'h60 || ram[12'h203] !== 8'h0C)
      begin errors++; $display("FAIL load_ram: %h %h %h %h, want A2 2A 60 0C",
        ram[12'h200], ram[12'h201], ram[12'h202], ram[12'h203]); end
    ld_valid = 1; ld_addr = 12'h250; ld_data = 8'h99; ld_done = 1;
    #1;
    checks++;
    if (mem_en !== 1'b0 || ld_ready !== 1'b0)
      begin errors++; $display("FAIL run_ld_ignored: en=%b rdy=%b, want 0 0", mem_en, ld_ready); end
    @(posedge clk); #1;
    ld_valid = 0; ld_done = 0;
    checks++;
    if (booted !== 1'b1 || ld_err !== 1'b1)
      begin errors++; $display("FAIL run_stays: booted=%b err=%b, want 1 1", booted, ld_err); end
  endtask

  task automatic test_contention;
    @(posedge clk); #1;
    cpu_valid = 1; cpu_we = 0; cpu_addr = 12'h200;
    gfx_valid = 1; gfx_addr = 12'h04F;
    #1;
    checks++;
    if (cpu_ready !== 1'b1 || gfx_ready !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h200)
      begin errors++; $display("FAIL cont_g1: cr=%b gr=%b en=%b we=%b addr=%h, want 1 0 1 0 200",
        cpu_ready, gfx_ready, mem_en, mem_we, mem_addr); end
    @(posedge clk); #1;
    cpu_addr = 12'h201;
    #1;
    checks++;
    if (cpu_ready !== 1'b0 || gfx_ready !== 1'b1 || mem_addr !== 12'h04F)
      begin errors++; $display("FAIL cont_g2: cr=%b gr=%b addr=%h, want 0 1 04F", cpu_ready, gfx_ready, mem_addr); end
    checks++;
    if (cpu_rvalid !== 1'b1 || gfx_rvalid !== 1'b0 || cpu_rdata !== ref_mem[12'h200])
      begin errors++; $display("FAIL cont_r1: crv=%b grv=%b data=%h, want 1 0 %h", cpu_rvalid, gfx_rvalid, cpu_rdata, ref_mem[12'h200]); end
    @(posedge clk); #1;
    gfx_valid = 0;
    #1;
    checks++;
    if (cpu_ready !== 1'b1 || mem_addr !== 12'h201)
      begin errors++; $display("FAIL cont_g3: cr=%b addr=%h, want 1 201", cpu_ready, mem_addr); end
    checks++;
    if (gfx_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || gfx_rdata !== ref_mem[12'h04F])
      begin errors++; $display("FAIL cont_r2: grv=%b crv=%b data=%h, want 1 0 %h", gfx_rvalid, cpu_rvalid, gfx_rdata, ref_mem[12'h04F]); end
    @(posedge clk); #1;
    cpu_valid = 0;
    #1;
    checks++;
    if (cpu_rvalid !== 1'b1 || gfx_rvalid !== 1'b0 || cpu_rdata !== ref_mem[12'h201] || gfx_rdata !== ref_mem[12'h04F])
      begin errors++; $display("FAIL cont_r3: crv=%b grv=%b cdata=%h gdata=%h, want 1 0 %h %h",
        cpu_rvalid, gfx_rvalid, cpu_rdata, gfx_rdata, ref_mem[12'h201], ref_mem[12'h04F]); end
    last_was_gfx = 1'b0;
  endtask

  task automatic test_write_read;
    @(posedge clk); #1;
    cpu_valid = 1; cpu_we = 1; cpu_addr = 12'h300; cpu_wdata = 8'h55;
    #1;
    checks++;
    if (cpu_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h300 || mem_wdata !== 8'h55)
      begin errors++; $display("FAIL wr_grant: cr=%b we=%b addr=%h data=%h, want 1 1 300 55", cpu_ready, mem_we, mem_addr, mem_wdata); end
    ref_mem[12'h300] = 8'h55;
    @(posedge clk); #1;
    cpu_we = 0;
    #1;
    checks++;
    if (cpu_rvalid !== 1'b0 || gfx_rvalid !== 1'b0 || cpu_ready !== 1'b1 || mem_we !== 1'b0)
      begin errors++; $display("FAIL wr_no_rvalid: crv=%b grv=%b cr=%b we=%b, want 0 0 1 0", cpu_rvalid, gfx_rvalid, cpu_ready, mem_we); end
    @(posedge clk); #1;
    cpu_valid = 0;
    #1;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h55 || gfx_rvalid !== 1'b0)
      begin errors++; $display("FAIL rd_after_wr: crv=%b data=%h grv=%b, want 1 55 0", cpu_rvalid, cpu_rdata, gfx_rvalid); end
    last_was_gfx = 1'b0;
  endtask

  task automatic test_random(input int n);
    logic        cpu_p = 0, gfx_p = 0, c_we = 0;
    logic [11:0] c_addr = '0, g_addr = '0;
    logic [7:0]  c_d = '0;
    logic        exp_crv = 0, exp_grv = 0, cpu_seen = 0, gfx_seen = 0;
    logic [7:0]  exp_cd = '0, exp_gd = '0, cpu_last = '0, gfx_last = '0;
    bit          give_cpu, give_gfx;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (cpu_rvalid !== exp_crv || gfx_rvalid !== exp_grv)
        begin errors++; $display("FAIL rand_rvalid %0d: crv=%b grv=%b, want %b %b", k, cpu_rvalid, gfx_rvalid, exp_crv, exp_grv); end
      if (exp_crv) begin
        checks++;
        if (cpu_rdata !== exp_cd) begin errors++; $display("FAIL rand_cpu_data %0d: %h, want %h", k, cpu_rdata, exp_cd); end
        cpu_last = exp_cd; cpu_seen = 1;
      end else if (cpu_seen) begin
        checks++;
        if (cpu_rdata !== cpu_last) begin errors++; $display("FAIL rand_cpu_hold %0d: %h, want %h", k, cpu_rdata, cpu_last); end
      end
      if (exp_grv) begin
        checks++;
        if (gfx_rdata !== exp_gd) begin errors++; $display("FAIL rand_gfx_data %0d: %h, want %h", k, gfx_rdata, exp_gd); end
        gfx_last = exp_gd; gfx_seen = 1;
      end else if (gfx_seen) begin
        checks++;
        if (gfx_rdata !== gfx_last) begin errors++; $display("FAIL rand_gfx_hold %0d: %h, want %h", k, gfx_rdata, gfx_last); end
      end
      if (!cpu_p && ($urandom % 3) != 0) begin
        cpu_p = 1; c_we = 1'($urandom % 2); c_addr = pick_addr(); c_d = 8'($urandom);
      end
      if (!gfx_p && ($urandom % 3) != 0) begin
        gfx_p = 1; g_addr = pick_addr();
      end
      cpu_valid = cpu_p; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_d;
      gfx_valid = gfx_p; gfx_addr = g_addr;
      #1;
      give_cpu = cpu_p && (!gfx_p || last_was_gfx);
      give_gfx = gfx_p && !give_cpu;
      checks++;
      if (cpu_ready !== give_cpu || gfx_ready !== give_gfx)
        begin errors++; $display("FAIL rand_grant %0d: cr=%b gr=%b, want %b %b", k, cpu_ready, gfx_ready, give_cpu, give_gfx); end
      exp_crv = 0; exp_grv = 0;
      if (give_cpu) begin
        checks++;
        if (mem_en !== 1'b1 || mem_we !== c_we || mem_addr !== c_addr || (c_we && mem_wdata !== c_d))
          begin errors++; $display("FAIL rand_cpu_mem %0d: en=%b we=%b addr=%h data=%h, want 1 %b %h %h",
            k, mem_en, mem_we, mem_addr, mem_wdata, c_we, c_addr, c_d); end
        if (c_we) ref_mem[c_addr] = c_d;
        else begin exp_crv = 1; exp_cd = ref_mem[c_addr]; end
        cpu_p = 0; last_was_gfx = 1'b0;
      end else if (give_gfx) begin
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== g_addr)
          begin errors++; $display("FAIL rand_gfx_mem %0d: en=%b we=%b addr=%h, want 1 0 %h", k, mem_en, mem_we, mem_addr, g_addr); end
        exp_grv = 1; exp_gd = ref_mem[g_addr];
        gfx_p = 0; last_was_gfx = 1'b1;
      end else begin
        checks++;
        if (mem_en !== 1'b0) begin errors++; $display("FAIL rand_idle %0d: en=%b, want 0", k, mem_en); end
      end
      @(posedge clk); #1;
    end
    cpu_valid = 0; gfx_valid = 0;
    #1;
    checks++;
    if (cpu_rvalid !== exp_crv || gfx_rvalid !== exp_grv || (exp_crv && cpu_rdata !== exp_cd) || (exp_grv && gfx_rdata !== exp_gd))
      begin errors++; $display("FAIL rand_drain: crv=%b grv=%b cd=%h gd=%h, want %b %b %h %h",
        cpu_rvalid, gfx_rvalid, cpu_rdata, gfx_rdata, exp_crv, exp_grv, exp_cd, exp_gd); end
  endtask

  task automatic test_reset_after_grant;
    @(posedge clk); #1;
    cpu_valid = 1; cpu_we = 0; cpu_addr = 12'h202;
    #1;
    checks++;
    if (cpu_ready !== 1'b1) begin errors++; $display("FAIL rst_grant: cr=%b, want 1", cpu_ready); end
    #1;
    test_reset();
  endtask

  initial begin
    font_bits = 640'hF0909090F0_2060202070_F010F080F0_F010F010F0_9090F01010_F080F010F0_F080F090F0_F010204040_F090F090F0_F090F010F0_F090F09090_E090E090E0_F0808080F0_E0909090E0_F080F080F0_F080F08080;
    for (int i = 0; i < 80; i++) font_exp[i] = font_bits[639 - 8*i -: 8];
    for (int i = 0; i < 4096; i++) begin ram[i] = 8'h00; ref_mem[i] = 8'h00; end
    last_was_gfx = 1'b1;
    #2;
    test_reset();
    test_font(80);
    test_load();
    test_contention();
    test_write_read();
    test_random(400);
    test_reset_after_grant();
    test_font(41);
    test_reset();
    test_font(80);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
